risc_v_mike_mem_arbiter: RTL and testbench

Two-port arbiter placed between the data-memory bus and its requesters: the core load/store port and an external port used by a program loader or debug agent. Each cycle it grants at most one requester and drives that requester's access onto the single shared memory port. It returns registered read data with a one-cycle response, and stalls the core while the external port owns the bus. Arbitration is fixed-priority to the core, with an external lock for bursts and an optional starvation guard.

---
 rtl/risc_v_mike_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_risc_v_mike_mem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_mike_mem_arbiter.sv
// risc_v_mike_mem_arbiter: core/external data-memory arbiter.
// Optional starvation guard: MEM_ARB_STARVE_GUARD_EN.
//
// Ports
//   clk, rst        : clock, async active-low reset
//   core_* / ext_*  : requester ports (req/we/addr/wdata in,
//                     gnt/stall/rvalid/rdata out)
//   ext_lock        : hold ext ownership across a burst
//   mem_*           : shared memory port, mem_rdata is comb
//
// Grants are combinational; read data is registered and
// returned with rvalid one cycle after the grant.

module risc_v_mike_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_stall,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CORE,
    ARB_EXT,
    ARB_LOCK
  } arb_state_t;

  arb_state_t state;
  arb_state_t state_nxt;
  logic       guard_trip;
  logic       core_rd;
  logic       ext_rd;

  // Starvation guard: count cycles ext has waited.
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!ext_req || ext_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign guard_trip = (wait_cnt == WAIT_MAX);
`else
  logic [7:0] unused_max_wait;

  assign unused_max_wait = 8'(MAX_WAIT);
  assign guard_trip      = 1'b0;
`endif

  // Grant decision; terms overlap, so order matters.
  // Nothing is granted while reset is held.
  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (rst) begin
      priority case (1'b1)
        (state == ARB_LOCK) && ext_req:
          ext_gnt = 1'b1;
        guard_trip && ext_req:
          ext_gnt = 1'b1;
        core_req:
          core_gnt = 1'b1;
        ext_req:
          ext_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  assign core_stall = core_req & ~core_gnt;
  assign ext_stall  = ext_req & ~ext_gnt;

  // State remembers who owned the bus last cycle;
  // only ARB_LOCK changes the next decision.
  always_comb begin
    state_nxt = ARB_IDLE;
    priority case (1'b1)
      ext_gnt && ext_lock: state_nxt = ARB_LOCK;
      ext_gnt:             state_nxt = ARB_EXT;
      core_gnt:            state_nxt = ARB_CORE;
      default:             state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shared port mux; all zero when idle.
  always_comb begin
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_addr  = core_addr;
      mem_write = core_we;
      mem_wdata = core_wdata;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_write = ext_we;
      mem_wdata = ext_wdata;
    end
  end

  assign core_rd = core_gnt & ~core_we;
  assign ext_rd  = ext_gnt & ~ext_we;

  // Read response: capture at the grant edge, flag for
  // one cycle, hold data until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      ext_rvalid  <= 1'b0;
      ext_rdata   <= '0;
    end else begin
      core_rvalid <= core_rd;
      ext_rvalid  <= ext_rd;
      if (core_rd) begin
        core_rdata <= mem_rdata;
      end
      if (ext_rd) begin
        ext_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_risc_v_mike_mem_arbiter.sv
// tb_risc_v_mike_mem_arbiter: scenario tasks plus random
// traffic against a behavioural arbiter/memory model.

module tb_risc_v_mike_mem_arbiter;

  localparam int MAXW = 8;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        ext_req, ext_we, ext_lock;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_stall, ext_rvalid;
  logic [31:0] ext_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;

  // Memory environment: 16 words, combinational read.
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
  end

  risc_v_mike_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt),
    .ext_stall(ext_stall), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  bit          locked;
  int          waitc;
  logic [31:0] ref_mem [16];
  bit          exp_crv, exp_erv;
  logic [31:0] exp_crd, exp_erd;
  bit          exp_cg, exp_eg, exp_we;
  logic [31:0] exp_addr, exp_wdata;

  task automatic model_eval();
    bit guard;
    guard = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard = (waitc == MAXW);
`endif
    exp_eg = rst && ext_req && (locked || guard || !core_req);
    exp_cg = rst && core_req && !exp_eg;
    exp_addr = 0; exp_we = 0; exp_wdata = 0;
    if (exp_cg) begin
      exp_addr = core_addr; exp_we = core_we;
      exp_wdata = core_wdata;
    end else if (exp_eg) begin
      exp_addr = ext_addr; exp_we = ext_we;
      exp_wdata = ext_wdata;
    end
  endtask

  task automatic tick();
    model_eval();
    if (!rst) begin
      locked = 0; waitc = 0;
      exp_crv = 0; exp_erv = 0;
      exp_crd = 0; exp_erd = 0;
    end else begin
      exp_crv = exp_cg && !core_we;
      exp_erv = exp_eg && !ext_we;
      if (exp_crv) exp_crd = ref_mem[core_addr[5:2]];
      if (exp_erv) exp_erd = ref_mem[ext_addr[5:2]];
      if (exp_cg && core_we) ref_mem[core_addr[5:2]] = core_wdata;
      if (exp_eg && ext_we) ref_mem[ext_addr[5:2]] = ext_wdata;
      locked = exp_eg && ext_lock;
      if (!ext_req || exp_eg) waitc = 0;
      else if (waitc < MAXW) waitc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    ext_lock = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    core_req = 1; core_we = 1; core_addr = BASE;
    ext_req = 1; ext_we = 1; ext_addr = BASE + 4;
    settle();
    vectors++;
    if (core_gnt !== 1'b0 || ext_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_gnt: core=%b ext=%b required 0 0", core_gnt, ext_gnt);
    end
    vectors++;
    if (mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mem_write: got %b required 0", mem_write);
    end
    tick(); tick();
    idle_inputs();
    rst = 1;
    settle();
    vectors++;
    if (core_rvalid !== 0 || ext_rvalid !== 0) begin
      miscompares++;
      $display("FAIL rst_rvalid: core=%b ext=%b required 0 0", core_rvalid, ext_rvalid);
    end
    vectors++;
    if (core_rdata !== 0 || ext_rdata !== 0) begin
      miscompares++;
      $display("FAIL rst_rdata: core=%h ext=%h required 0 0", core_rdata, ext_rdata);
    end
    tick();
  endtask

  task automatic test_core_read();
    mem[0] = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;
    idle_inputs();
    core_req = 1; core_addr = BASE;
    settle();
    vectors++;
    if (core_gnt !== 1'b1 || mem_addr !== BASE) begin
      miscompares++;
      $display("FAIL rd_gnt: gnt=%b addr=%h required 1 %h", core_gnt, mem_addr, BASE);
    end
    tick();
    core_req = 0;
    settle();
    vectors++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rd_data: rvalid=%b rdata=%h required 1 deadbeef", core_rvalid, core_rdata);
    end
    tick();
    settle();
    vectors++;
    if (core_rvalid !== 1'b0 || core_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rd_hold: rvalid=%b rdata=%h required 0 deadbeef", core_rvalid, core_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    bit ext_exp;
    idle_inputs();
    core_req = 1; core_addr = BASE + 8;
    ext_req = 1; ext_addr = BASE + 12;
    for (int i = 1; i <= 12; i++) begin
      settle();
      ext_exp = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      ext_exp = (i == MAXW + 1);
`endif
      vectors++;
      if (ext_gnt !== ext_exp || core_gnt !== !ext_exp || ext_stall !== !ext_exp) begin
        miscompares++;
        $display("FAIL contend cyc %0d: core_gnt=%b ext_gnt=%b ext_stall=%b required ext_gnt=%b",
                 i, core_gnt, ext_gnt, ext_stall, ext_exp);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lock_burst();
    idle_inputs();
    ext_req = 1; ext_we = 1; ext_lock = 1;
    for (int b = 0; b < 4; b++) begin
      ext_addr = BASE + 32'(16 + 4 * b);
      ext_wdata = 32'hB000_0000 + 32'(b);
      settle();
      vectors++;
      if (ext_gnt !== 1'b1 || core_gnt !== 1'b0 || (b > 0 && core_stall !== 1'b1)) begin
        miscompares++;
        $display("FAIL burst beat %0d: ext_gnt=%b core_gnt=%b core_stall=%b required 1 0 1",
                 b, ext_gnt, core_gnt, core_stall);
      end
      tick();
      core_req = 1; core_addr = BASE + 16;
    end
    ext_req = 0;
    settle();
    vectors++;
    if (core_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_release: core_gnt=%b required 1", core_gnt);
    end
    tick();
    core_req = 0;
    settle();
    vectors++;
    if (core_rdata !== 32'hB000_0000) begin
      miscompares++;
      $display("FAIL burst_readback: got %h required b0000000", core_rdata);
    end
    tick();
  endtask

  task automatic test_idle();
    idle_inputs();
    core_addr = 32'hFFFF_FFFF; ext_wdata = 32'h1234_5678;
    settle();
    vectors++;
    if (mem_write !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      miscompares++;
      $display("FAIL idle_bus: we=%b addr=%h wdata=%h required 0 0 0", mem_write, mem_addr, mem_wdata);
    end
    vectors++;
    if (core_gnt !== 0 || ext_gnt !== 0) begin
      miscompares++;
      $display("FAIL idle_gnt: core=%b ext=%b required 0 0", core_gnt, ext_gnt);
    end
    tick();
  endtask

  task automatic test_write_then_read();
    idle_inputs();
    ext_req = 1; ext_we = 1; ext_addr = BASE + 4;
    ext_wdata = 32'h0000_00A5;
    settle();
    vectors++;
    if (ext_gnt !== 1 || mem_write !== 1 || mem_addr !== BASE + 4 || mem_wdata !== 32'hA5) begin
      miscompares++;
      $display("FAIL wr_issue: gnt=%b we=%b addr=%h wdata=%h required 1 1 10010004 a5",
               ext_gnt, mem_write, mem_addr, mem_wdata);
    end
    tick();
    idle_inputs();
    core_req = 1; core_addr = BASE + 4;
    settle();
    vectors++;
    if (ext_rvalid !== 0 || core_gnt !== 1) begin
      miscompares++;
      $display("FAIL wr_then_rd: ext_rvalid=%b core_gnt=%b required 0 1", ext_rvalid, core_gnt);
    end
    tick();
    core_req = 0;
    settle();
    vectors++;
    if (core_rvalid !== 1 || core_rdata !== 32'hA5 || ext_rvalid !== 0) begin
      miscompares++;
      $display("FAIL rd_after_wr: rvalid=%b rdata=%h ext_rvalid=%b required 1 a5 0",
               core_rvalid, core_rdata, ext_rvalid);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    idle_inputs();
    ext_req = 1; ext_addr = BASE + 4;
    settle();
    vectors++;
    if (ext_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_gnt: got %b required 1", ext_gnt);
    end
    rst = 0;
    #1;
    vectors++;
    if (ext_gnt !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL inflight_gate: gnt=%b we=%b required 0 0", ext_gnt, mem_write);
    end
    tick();
    ext_req = 0;
    settle();
    vectors++;
    if (ext_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL inflight_rvalid: got %b required 0", ext_rvalid);
    end
    tick();
    rst = 1;
    settle();
    vectors++;
    if (ext_rvalid !== 0 || ext_rdata !== 0 || core_rvalid !== 0 || core_rdata !== 0
        || mem_addr !== 0 || mem_wdata !== 0) begin
      miscompares++;
      $display("FAIL post_reset: erv=%b erd=%h crv=%b crd=%h addr=%h wd=%h required all 0",
               ext_rvalid, ext_rdata, core_rvalid, core_rdata, mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_random();
    bit c_pend = 0;
    bit e_pend = 0;
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      if (!c_pend || $urandom_range(0, 15) == 0) begin
        core_req = ($urandom_range(0, 2) != 0);
        core_we = 1'($urandom_range(0, 1));
        core_addr = BASE | 32'($urandom_range(0, 15) << 2);
        core_wdata = $urandom;
      end
      if (!e_pend || $urandom_range(0, 15) == 0) begin
        ext_req = ($urandom_range(0, 2) != 0);
        ext_we = 1'($urandom_range(0, 1));
        ext_addr = BASE | 32'($urandom_range(0, 15) << 2);
        ext_wdata = $urandom;
      end
      ext_lock = ($urandom_range(0, 3) == 0);
      settle();
      vectors++;
      if (core_gnt !== exp_cg || ext_gnt !== exp_eg) begin
        miscompares++;
        $display("FAIL rnd_gnt %0d: core=%b ext=%b required %b %b", n, core_gnt, ext_gnt, exp_cg, exp_eg);
      end
      vectors++;
      if (core_stall !== (core_req && !exp_cg) || ext_stall !== (ext_req && !exp_eg)) begin
        miscompares++;
        $display("FAIL rnd_stall %0d: core=%b ext=%b", n, core_stall, ext_stall);
      end
      vectors++;
      if (mem_addr !== exp_addr || mem_write !== exp_we || mem_wdata !== exp_wdata) begin
        miscompares++;
        $display("FAIL rnd_bus %0d: addr=%h we=%b wd=%h required %h %b %h",
                 n, mem_addr, mem_write, mem_wdata, exp_addr, exp_we, exp_wdata);
      end
      vectors++;
      if (core_rvalid !== exp_crv || core_rdata !== exp_crd) begin
        miscompares++;
        $display("FAIL rnd_core_rd %0d: rv=%b rd=%h required %b %h", n, core_rvalid, core_rdata, exp_crv, exp_crd);
      end
      vectors++;
      if (ext_rvalid !== exp_erv || ext_rdata !== exp_erd) begin
        miscompares++;
        $display("FAIL rnd_ext_rd %0d: rv=%b rd=%h required %b %h", n, ext_rvalid, ext_rdata, exp_erv, exp_erd);
      end
      c_pend = core_req && !exp_cg;
      e_pend = ext_req && !exp_eg;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    locked = 0; waitc = 0;
    exp_crv = 0; exp_erv = 0; exp_crd = 0; exp_erd = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 0;
      ref_mem[i] = 0;
    end
    #1;
    test_reset();
    test_core_read();
    test_contention();
    test_lock_burst();
    test_idle();
    test_write_then_read();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
